// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: req/ack data bus, load/store formatting, MEM/WB registers
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] write_data_mem,
   input  logic [1:0]  wb_sel_mem,
   input  logic [1:0]  read_width_mem,
   input  logic [4:0]  wrt_dst_mem,
   input  logic        mem_wrt_en_mem,
   input  logic        rd_en_mem,
   input  logic        reg_wrt_en_mem,
   input  logic        read_unsigned_mem,
   input  logic        rdi_mem,
   input  logic [31:0] iface_rdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        stall_mem,
   output logic        misalign_err,
   output logic        bus_err,
   output logic [31:0] mem_data_wb,
   output logic [31:0] alu_result_wb,
   output logic [31:0] next_pc_wb,
   output logic [1:0]  wb_sel_wb,
   output logic [4:0]  wrt_dst_wb,
   output logic        reg_wrt_en_wb
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             access, is_load, misaligned, start, timeout_hit;
   logic             aborted;
   logic [31:0]      load_buf, load_fmt, store_wdata;
   logic [3:0]       store_be;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic             wb_load, wb_wen;
   logic [31:0]      wb_data;

   // rd_en together with wrt_en is a store; rdi never touches the bus
   assign access     = (mem_wrt_en_mem | rd_en_mem) & ~rdi_mem;
   assign is_load    = rd_en_mem & ~mem_wrt_en_mem;
   assign misaligned = access & (((read_width_mem == 2'b01) & alu_result_mem[0]) |
                                 (read_width_mem[1] & (alu_result_mem[1:0] != 2'b00)));
   assign start      = access & ~misaligned;

   assign cnt_inc     = cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

   always_comb begin
      byte_lane = dmem_rdata[7:0];
      case (alu_result_mem[1:0])
         2'd0:    byte_lane = dmem_rdata[7:0];
         2'd1:    byte_lane = dmem_rdata[15:8];
         2'd2:    byte_lane = dmem_rdata[23:16];
         default: byte_lane = dmem_rdata[31:24];
      endcase
      half_lane = alu_result_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (read_width_mem)
         2'b00:   load_fmt = read_unsigned_mem ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_fmt = read_unsigned_mem ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      case (read_width_mem)
         2'b00: begin
            store_be    = 4'b0001 << alu_result_mem[1:0];
            store_wdata = {4{write_data_mem[7:0]}};
         end
         2'b01: begin
            store_be    = 4'b0011 << {alu_result_mem[1], 1'b0};
            store_wdata = {2{write_data_mem[15:0]}};
         end
         default: begin
            store_be    = 4'hF;
            store_wdata = write_data_mem;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      stall_mem  = 1'b0;
      case (state)
         IDLE: if (start) begin
            stall_mem  = 1'b1;
            state_next = REQ;
         end
         REQ: begin
            stall_mem = 1'b1;
            if (dmem_ack || timeout_hit) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // WB registers hold across the whole stalled access and load once in DONE
   assign wb_load = ((state == IDLE) && !start) || (state == DONE);
   assign wb_data = (state == DONE) ? load_buf : (rdi_mem ? iface_rdata : 32'b0);
   assign wb_wen  = reg_wrt_en_mem & ~((state == DONE) ? aborted : misaligned);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'b0;
         dmem_wdata   <= 32'b0;
         dmem_be      <= 4'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         cnt          <= '0;
         aborted      <= 1'b0;
         load_buf     <= 32'b0;
      end else begin
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         case (state)
            IDLE: begin
               misalign_err <= misaligned;
               if (start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_wrt_en_mem;
                  dmem_addr  <= {alu_result_mem[31:2], 2'b00};
                  dmem_be    <= store_be;
                  dmem_wdata <= store_wdata;
                  cnt        <= '0;
                  aborted    <= 1'b0;
                  load_buf   <= 32'b0;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  load_buf <= is_load ? load_fmt : 32'b0;
               end else if (timeout_hit) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  bus_err  <= 1'b1;
                  aborted  <= 1'b1;
                  load_buf <= 32'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_data_wb   <= 32'b0;
         alu_result_wb <= 32'b0;
         next_pc_wb    <= 32'b0;
         wb_sel_wb     <= 2'b0;
         wrt_dst_wb    <= 5'b0;
         reg_wrt_en_wb <= 1'b0;
      end else if (wb_load) begin
         mem_data_wb   <= wb_data;
         alu_result_wb <= alu_result_mem;
         next_pc_wb    <= next_pc_mem;
         wb_sel_wb     <= wb_sel_mem;
         wrt_dst_wb    <= wrt_dst_mem;
         reg_wrt_en_wb <= wb_wen;
      end
   end

endmodule
